// File: rtl/programmable_divider.sv
// Programmable clock divider: terminal-count pulse plus near-50% square wave, divisor reprogrammable at run time.
// Latency: pulse and square are decoded directly from registers; start/stop/divisor writes act on the next edge.
// Backpressure: none; inputs are plain strobes sampled every cycle and never stalled.
//
// Ports:
//   Origin_Clock  sole clock, rising-edge
//   reset         synchronous active-high reset, highest priority
//   start         enter RUN (or restart the period when already running)
//   stop          abort to IDLE; wins over start
//   oneshot       sampled with start: 1 = single period then DONE, 0 = periodic
//   div_wr/div_in divisor write strobe and value (zero is rejected and flagged)
//   pulse         one-cycle terminal-count pulse
//   square        divided clock, high for the upper half of the period
//   busy          high while in RUN
//   count         current count value
//   div_cur       divisor currently in use
//   div_err       sticky: a zero divisor was written since reset
module programmable_divider #(
   parameter int WIDTH       = 24,
   parameter int DEFAULT_DIV = 10000000
) (
   input  logic             Origin_Clock,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             oneshot,
   input  logic             div_wr,
   input  logic [WIDTH-1:0] div_in,
   output logic             pulse,
   output logic             square,
   output logic             busy,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] div_cur,
   output logic             div_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   state_t           state_q,    state_d;
   logic [WIDTH-1:0] count_q,    count_d;
   logic [WIDTH-1:0] div_cur_q,  div_cur_d;
   logic [WIDTH-1:0] pend_q,     pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic             oneshot_q,  oneshot_d;
   logic             div_err_q,  div_err_d;

   logic wrap;
   logic wr_ok;
   logic apply_run;

   // Terminal cycle of the current period.
   assign wrap  = (state_q == S_RUN) && (count_q == (div_cur_q - ONE));
   assign wr_ok = div_wr && (div_in != '0);
   // While running, a new divisor may only land on a period boundary: the
   // natural wrap or a restart. A stop is not a boundary; the pending value
   // is picked up once IDLE is reached.
   assign apply_run = (state_q == S_RUN) && !stop && (wrap || start);

   // State register
   always_ff @(posedge Origin_Clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         div_cur_q  <= DEF_DIV;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         oneshot_q  <= 1'b0;
         div_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         div_cur_q  <= div_cur_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         oneshot_q  <= oneshot_d;
         div_err_q  <= div_err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      div_cur_d  = div_cur_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      oneshot_d  = oneshot_q;
      div_err_d  = div_err_q | (div_wr && (div_in == '0));

      // Control: stop beats start, start beats normal counting.
      if (stop) begin
         state_d = S_IDLE;
         count_d = '0;
      end else if (start) begin
         state_d   = S_RUN;
         count_d   = '0;
         oneshot_d = oneshot;
      end else begin
         case (state_q)
            S_RUN: begin
               if (wrap) begin
                  count_d = '0;
                  if (oneshot_q) state_d = S_DONE;
               end else begin
                  count_d = count_q + ONE;
               end
            end
            default: count_d = '0;
         endcase
      end

      // Divisor update. At a run boundary a same-cycle write wins over the
      // pending value and bypasses the pending register.
      if (apply_run) begin
         if (wr_ok) begin
            div_cur_d  = div_in;
            pend_vld_d = 1'b0;
         end else if (pend_vld_q) begin
            div_cur_d  = pend_q;
            pend_vld_d = 1'b0;
         end
      end else if ((state_q != S_RUN) && pend_vld_q) begin
         // Idle/done: drain the pending value; a fresh write refills it.
         div_cur_d  = pend_q;
         pend_vld_d = wr_ok;
         if (wr_ok) pend_d = div_in;
      end else if (wr_ok) begin
         pend_d     = div_in;
         pend_vld_d = 1'b1;
      end
   end

   // Outputs, decoded straight from registers
   always_comb begin
      busy    = (state_q == S_RUN);
      pulse   = wrap;
      square  = (state_q == S_RUN) && (count_q >= (div_cur_q >> 1));
      count   = count_q;
      div_cur = div_cur_q;
      div_err = div_err_q;
   end

endmodule

// File: tb/tb_programmable_divider.sv
module tb_programmable_divider;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset, start, stop, oneshot, div_wr;
   logic [W-1:0] div_in;
   logic         pulse, square, busy, div_err;
   logic [W-1:0] count, div_cur;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int exp_q[$];
   int got_q[$];

   programmable_divider #(.WIDTH(W), .DEFAULT_DIV(5)) dut (
      .Origin_Clock(clk),
      .reset(reset),
      .start(start),
      .stop(stop),
      .oneshot(oneshot),
      .div_wr(div_wr),
      .div_in(div_in),
      .pulse(pulse),
      .square(square),
      .busy(busy),
      .count(count),
      .div_cur(div_cur),
      .div_err(div_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // One clock: inputs are consumed at the rising edge, outputs sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Record the cycle numbers of observed pulses while advancing n cycles.
   task automatic collect(input int n);
      for (int i = 0; i < n; i++) begin
         if (pulse === 1'b1) got_q.push_back(cyc);
         step();
      end
   endtask

   task automatic do_start(input logic os);
      oneshot = os; start = 1'b1;
      step();
      start = 1'b0; oneshot = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
      checks++; if (pulse !== 1'b0 || square !== 1'b0) begin errors++; $display("FAIL reset_pulse_square got %0b%0b want 00", pulse, square); end
      checks++; if (div_cur !== 8'd5) begin errors++; $display("FAIL reset_div_cur got %0d want 5", div_cur); end
      checks++; if (div_err !== 1'b0) begin errors++; $display("FAIL reset_div_err got %0b want 0", div_err); end
   endtask

   task automatic test_periodic();
      int t, g, e;
      got_q.delete(); exp_q.delete();
      do_start(1'b0);
      t = cyc;
      exp_q.push_back(t + 4); exp_q.push_back(t + 9); exp_q.push_back(t + 14);
      for (int i = 0; i < 15; i++) begin
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL periodic_busy i=%0d got %0b want 1", i, busy); end
         checks++; if (count !== 8'(i % 5)) begin errors++; $display("FAIL periodic_count i=%0d got %0d want %0d", i, count, i % 5); end
         checks++; if (square !== ((i % 5) >= 2)) begin errors++; $display("FAIL periodic_square i=%0d got %0b want %0b", i, square, (i % 5) >= 2); end
         collect(1);
      end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL periodic_npulse got %0d want %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         checks++; if (g != e) begin errors++; $display("FAIL periodic_pulse_cyc got %0d want %0d", g, e); end
      end
      do_stop();
      checks++; if (busy !== 1'b0 || count !== 8'd0) begin errors++; $display("FAIL periodic_stop got busy=%0b count=%0d want 0 0", busy, count); end
   endtask

   task automatic test_div_change();
      int t, g, e;
      got_q.delete(); exp_q.delete();
      do_start(1'b0);
      t = cyc;
      exp_q.push_back(t + 4); exp_q.push_back(t + 7); exp_q.push_back(t + 10); exp_q.push_back(t + 13);
      collect(1);
      div_wr = 1'b1; div_in = 8'd3;
      collect(1);
      div_wr = 1'b0;
      collect(2);
      checks++; if (div_cur !== 8'd5 || count !== 8'd4) begin errors++; $display("FAIL divchg_midperiod got div=%0d count=%0d want 5 4", div_cur, count); end
      collect(1);
      checks++; if (div_cur !== 8'd3 || count !== 8'd0) begin errors++; $display("FAIL divchg_after_wrap got div=%0d count=%0d want 3 0", div_cur, count); end
      collect(9);
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL divchg_npulse got %0d want %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         checks++; if (g != e) begin errors++; $display("FAIL divchg_pulse_cyc got %0d want %0d", g, e); end
      end
      do_stop();
   endtask

   task automatic test_div_zero();
      int t, g, e;
      got_q.delete(); exp_q.delete();
      do_start(1'b0);
      t = cyc;
      exp_q.push_back(t + 2); exp_q.push_back(t + 5); exp_q.push_back(t + 8);
      collect(1);
      div_wr = 1'b1; div_in = 8'd0;
      collect(1);
      div_wr = 1'b0;
      checks++; if (div_err !== 1'b1) begin errors++; $display("FAIL divzero_err got %0b want 1", div_err); end
      collect(7);
      checks++; if (div_cur !== 8'd3) begin errors++; $display("FAIL divzero_div_cur got %0d want 3", div_cur); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL divzero_npulse got %0d want %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         checks++; if (g != e) begin errors++; $display("FAIL divzero_pulse_cyc got %0d want %0d", g, e); end
      end
      do_stop();
      step();
      checks++; if (div_err !== 1'b1 || div_cur !== 8'd3) begin errors++; $display("FAIL divzero_sticky got err=%0b div=%0d want 1 3", div_err, div_cur); end
   endtask

   task automatic test_wrap_bypass();
      int t, g, e;
      got_q.delete(); exp_q.delete();
      do_start(1'b0);
      t = cyc;
      exp_q.push_back(t + 2); exp_q.push_back(t + 4); exp_q.push_back(t + 6);
      collect(2);
      div_wr = 1'b1; div_in = 8'd2;
      collect(1);
      div_wr = 1'b0;
      checks++; if (div_cur !== 8'd2 || count !== 8'd0) begin errors++; $display("FAIL bypass_div_cur got div=%0d count=%0d want 2 0", div_cur, count); end
      collect(4);
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bypass_npulse got %0d want %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         checks++; if (g != e) begin errors++; $display("FAIL bypass_pulse_cyc got %0d want %0d", g, e); end
      end
      do_stop();
   endtask

   task automatic test_oneshot();
      int t, g, e;
      div_wr = 1'b1; div_in = 8'd4;
      step();
      div_wr = 1'b0;
      step();
      checks++; if (div_cur !== 8'd4) begin errors++; $display("FAIL oneshot_idle_load got %0d want 4", div_cur); end
      got_q.delete(); exp_q.delete();
      do_start(1'b1);
      t = cyc;
      exp_q.push_back(t + 3);
      collect(4);
      checks++; if (busy !== 1'b0 || count !== 8'd0) begin errors++; $display("FAIL oneshot_done got busy=%0b count=%0d want 0 0", busy, count); end
      collect(20);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL oneshot_stays_done got busy=%0b want 0", busy); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL oneshot_npulse got %0d want %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         checks++; if (g != e) begin errors++; $display("FAIL oneshot_pulse_cyc got %0d want %0d", g, e); end
      end
   endtask

   task automatic test_start_stop();
      do_start(1'b0);
      collect(2);
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      checks++; if (busy !== 1'b0 || count !== 8'd0 || pulse !== 1'b0) begin errors++; $display("FAIL startstop got busy=%0b count=%0d pulse=%0b want 0 0 0", busy, count, pulse); end
      do_start(1'b0);
      collect(3);
      checks++; if (count !== 8'd3) begin errors++; $display("FAIL midrun_count got %0d want 3", count); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++; if (busy !== 1'b0 || count !== 8'd0) begin errors++; $display("FAIL midrst_state got busy=%0b count=%0d want 0 0", busy, count); end
      checks++; if (pulse !== 1'b0 || square !== 1'b0) begin errors++; $display("FAIL midrst_outs got pulse=%0b square=%0b want 0 0", pulse, square); end
      checks++; if (div_cur !== 8'd5 || div_err !== 1'b0) begin errors++; $display("FAIL midrst_div got div=%0d err=%0b want 5 0", div_cur, div_err); end
   endtask

   task automatic test_restart();
      int t, g, e;
      do_start(1'b0);
      collect(1);
      div_wr = 1'b1; div_in = 8'd2;
      collect(1);
      div_wr = 1'b0;
      checks++; if (div_cur !== 8'd5) begin errors++; $display("FAIL restart_pending_held got %0d want 5", div_cur); end
      got_q.delete(); exp_q.delete();
      do_start(1'b0);
      t = cyc;
      exp_q.push_back(t + 1); exp_q.push_back(t + 3); exp_q.push_back(t + 5);
      checks++; if (count !== 8'd0 || div_cur !== 8'd2 || busy !== 1'b1) begin errors++; $display("FAIL restart_apply got count=%0d div=%0d busy=%0b want 0 2 1", count, div_cur, busy); end
      collect(6);
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL restart_npulse got %0d want %0d", got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         checks++; if (g != e) begin errors++; $display("FAIL restart_pulse_cyc got %0d want %0d", g, e); end
      end
      do_stop();
   endtask

   task automatic test_div_one();
      div_wr = 1'b1; div_in = 8'd1;
      step();
      div_wr = 1'b0;
      do_start(1'b0);
      checks++; if (div_cur !== 8'd1) begin errors++; $display("FAIL divone_div_cur got %0d want 1", div_cur); end
      for (int i = 0; i < 6; i++) begin
         checks++; if ({busy, pulse, square} !== 3'b111) begin errors++; $display("FAIL divone_outs i=%0d got %03b want 111", i, {busy, pulse, square}); end
         step();
      end
      do_stop();
      checks++; if (busy !== 1'b0 || pulse !== 1'b0) begin errors++; $display("FAIL divone_stop got busy=%0b pulse=%0b want 0 0", busy, pulse); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; oneshot = 1'b0;
      div_wr = 1'b0; div_in = '0;
      @(negedge clk);
      test_reset();
      test_periodic();
      test_div_change();
      test_div_zero();
      test_wrap_bypass();
      test_oneshot();
      test_start_stop();
      test_restart();
      test_div_one();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
